// File: rtl/uart_alu_interface.sv
// Byte sequencer between a UART receiver, a combinational ALU and a UART transmitter.
// Collects operand A, operand B and opcode, then sends the ALU result back out.
module uart_alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done_tick,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic [NB_DATA-1:0] alu_result,
    input  logic               tx_done_tick,
    output logic [NB_DATA-1:0] alu_a,
    output logic [NB_DATA-1:0] alu_b,
    output logic [NB_OP-1:0]   alu_op,
    output logic               tx_start,
    output logic [NB_DATA-1:0] tx_data,
    output logic               busy,
    output logic               rx_overrun
);

    localparam logic [2:0] WAIT_A  = 3'd0;
    localparam logic [2:0] WAIT_B  = 3'd1;
    localparam logic [2:0] WAIT_OP = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] WAIT_TX = 3'd4;

    logic [2:0] state;

    assign busy = (state == EXEC) || (state == WAIT_TX);

    // NOTE: all state uses non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT_A;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            rx_overrun <= 1'b0;
        end else begin
            // Default low makes tx_start a single-cycle pulse out of EXEC.
            tx_start <= 1'b0;

            if (rx_done_tick && busy)
                rx_overrun <= 1'b1;

            case (state)
                WAIT_A: begin
                    if (rx_done_tick) begin
                        alu_a <= rx_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (rx_done_tick) begin
                        alu_b <= rx_data;
                        state <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (rx_done_tick) begin
                        alu_op <= rx_data[NB_OP-1:0];
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU has had a full cycle to settle on the registered operands.
                    tx_data  <= alu_result;
                    tx_start <= 1'b1;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done_tick)
                        state <= WAIT_A;
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule
